reg_bank_reader: RTL

//  Read-side sequencer for the CPU's bank of 8-bit registers. On START it walks the

---
 rtl/reg_bank_reader.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/reg_bank_reader.sv
// Read-side sequencer for a bank of registers: walks first..last (wrapping at
// NUM_REGS-1) and streams {address, data} words over a valid/ready handshake.
module reg_bank_reader #(
   parameter int unsigned NUM_REGS = 8,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ADDR_W   = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] first_addr,
   input  logic [ADDR_W-1:0] last_addr,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int unsigned AW = ADDR_W;
   localparam int unsigned DW = DATA_W;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   cur_q, cur_d;
   logic [AW-1:0]   last_q, last_d;
   logic            rd_en_q, rd_en_d;
   logic [AW-1:0]   rd_addr_q, rd_addr_d;
   logic            out_valid_q, out_valid_d;
   logic [AW-1:0]   out_addr_q, out_addr_d;
   logic [DW-1:0]   out_data_q, out_data_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            err_q, err_d;

   logic [31:0]     first_ext_c;
   logic [31:0]     last_ext_c;
   logic            range_ok_c;
   logic [AW-1:0]   next_cur_c;

   // Address range check and wrap-around successor of the current address
   always_comb begin
      first_ext_c = 32'(first_addr);
      last_ext_c  = 32'(last_addr);
      range_ok_c  = (first_ext_c < NUM_REGS) && (last_ext_c < NUM_REGS);
      next_cur_c  = (cur_q == AW'(NUM_REGS - 1)) ? '0 : cur_q + AW'(1);
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      last_d      = last_q;
      rd_en_d     = 1'b0;
      rd_addr_d   = rd_addr_q;
      out_valid_d = out_valid_q;
      out_addr_d  = out_addr_q;
      out_data_d  = out_data_q;
      done_d      = 1'b0;
      err_d       = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (range_ok_c) begin
                  cur_d     = first_addr;
                  last_d    = last_addr;
                  rd_en_d   = 1'b1;
                  rd_addr_d = first_addr;
                  state_d   = S_ISSUE;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            out_data_d  = rd_data;
            out_addr_d  = cur_q;
            out_valid_d = 1'b1;
            state_d     = S_HOLD;
         end
         S_HOLD: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               if (cur_q == last_q) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  cur_d     = next_cur_c;
                  rd_en_d   = 1'b1;
                  rd_addr_d = next_cur_c;
                  state_d   = S_ISSUE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cur_q       <= '0;
         last_q      <= '0;
         rd_en_q     <= 1'b0;
         rd_addr_q   <= '0;
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         last_q      <= last_d;
         rd_en_q     <= rd_en_d;
         rd_addr_q   <= rd_addr_d;
         out_valid_q <= out_valid_d;
         out_addr_q  <= out_addr_d;
         out_data_q  <= out_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign rd_en     = rd_en_q;
   assign rd_addr   = rd_addr_q;
   assign out_valid = out_valid_q;
   assign out_addr  = out_addr_q;
   assign out_data  = out_data_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule
